// File: rtl/dfs_level_ctrl.sv
// Activity-driven frequency level controller producing a divided clock-enable pulse.
// Define DFS_OVERRIDE_EN to add the force_en/force_level manual level override ports.
module dfs_level_ctrl #(
  parameter int NUM_LEVELS = 4,
  parameter int LVL_W      = 2,
  parameter int WIN_LEN    = 1024,
  parameter int HI_THR     = 768,
  parameter int LO_THR     = 256,
  parameter int DWELL      = 2
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic             dfs_en,
  input  logic             act_in,
  output logic             clk_en,
  output logic [LVL_W-1:0] level,
  output logic             level_chg,
  output logic [15:0]      act_cnt
`ifdef DFS_OVERRIDE_EN
  ,
  input  logic             force_en,
  input  logic [LVL_W-1:0] force_level
`endif
);

  typedef enum logic [2:0] {IDLE, MEASURE, DECIDE, PEND, HOLD} state_t;

  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(NUM_LEVELS - 1);
  localparam logic [15:0]      WIN_LAST = 16'(WIN_LEN - 1);

  state_t                  state, state_nx;
  logic [NUM_LEVELS-1:0]   div_cnt, div_max;
  logic [15:0]             win_cnt, evt_cnt, evt_sum;
  logic [3:0]              dwell;
  logic [LVL_W-1:0]        target, target_nx;
  logic                    change_ok;

  // Terminal count 2^(level+1)-1 is a run of level+1 ones.
  always_comb begin
    div_max = '0;
    for (int unsigned i = 0; i < NUM_LEVELS; i++)
      if (i <= 32'(level)) div_max[i] = 1'b1;
  end

  assign clk_en  = (div_cnt == div_max);
  assign evt_sum = (act_in && (evt_cnt != '1)) ? evt_cnt + 16'd1 : evt_cnt;

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n)      div_cnt <= '0;
    else if (clk_en) div_cnt <= '0;
    else             div_cnt <= div_cnt + 1'b1;
  end

  // Automatic step is clamped at both ends; override bypasses thresholds and dwell.
  always_comb begin
    target_nx = level;
    change_ok = (dwell == '0);
    if (act_cnt >= 16'(HI_THR)) begin
      if (level != '0) target_nx = level - 1'b1;
    end else if (act_cnt <= 16'(LO_THR)) begin
      if (level != LVL_MAX) target_nx = level + 1'b1;
    end
`ifdef DFS_OVERRIDE_EN
    if (force_en) begin
      target_nx = (force_level > LVL_MAX) ? LVL_MAX : force_level;
      change_ok = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    level_chg = 1'b0;
    case (state)
      IDLE:    if (dfs_en) state_nx = MEASURE;
      MEASURE: if (win_cnt == WIN_LAST) state_nx = DECIDE;
      DECIDE:  state_nx = (change_ok && (target_nx != level)) ? PEND : MEASURE;
      PEND:    if (clk_en) state_nx = HOLD;
      HOLD: begin
        level_chg = 1'b1;
        state_nx  = MEASURE;
      end
      default: state_nx = IDLE;
    endcase
    if (!dfs_en) state_nx = IDLE;
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      level   <= LVL_MAX;
      target  <= LVL_MAX;
      win_cnt <= '0;
      evt_cnt <= '0;
      act_cnt <= '0;
      dwell   <= '0;
    end else begin
      if (!dfs_en || state != MEASURE) begin
        win_cnt <= '0;
        evt_cnt <= '0;
      end else if (win_cnt == WIN_LAST) begin
        win_cnt <= '0;
        evt_cnt <= '0;
        act_cnt <= evt_sum;
        if (dwell != '0) dwell <= dwell - 1'b1;
      end else begin
        win_cnt <= win_cnt + 16'd1;
        evt_cnt <= evt_sum;
      end
      if (state == DECIDE) target <= target_nx;
      // Level switches on the wrap edge so the old period always completes.
      if (state == PEND && state_nx == HOLD) begin
        level <= target;
        dwell <= 4'(DWELL);
      end
    end
  end

endmodule

// File: tb/tb_dfs_level_ctrl.sv
// Self-checking bench for dfs_level_ctrl: table of activity runs plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_dfs_level_ctrl;
  localparam int NL = 4;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dfs_en = 1'b0;
  logic          act_in = 1'b0;
  logic          clk_en, level_chg;
  logic [LW-1:0] level;
  logic [15:0]   act_cnt;
`ifdef DFS_OVERRIDE_EN
  logic          force_en = 1'b0;
  logic [LW-1:0] force_level = '0;
`endif

  dfs_level_ctrl #(
    .NUM_LEVELS(NL), .LVL_W(LW), .WIN_LEN(64), .HI_THR(48), .LO_THR(16), .DWELL(2)
  ) dut (
    .clk_100mhz(clk),
    .rst_n(rst_n),
    .dfs_en(dfs_en),
    .act_in(act_in),
    .clk_en(clk_en),
    .level(level),
    .level_chg(level_chg),
    .act_cnt(act_cnt)
`ifdef DFS_OVERRIDE_EN
    , .force_en(force_en),
    .force_level(force_level)
`endif
  );

  always #5 clk = ~clk;

  typedef enum {M_LO, M_HI, M_TOG} mode_t;
  typedef struct {
    mode_t mode;
    int    cycles;
    int    exp_act;
    int    exp_lvl;
  } rec_t;

  mode_t mode = M_LO;
  int    total = 0;
  int    bad = 0;
  int    exp_q[$];
  int    cur_lvl = NL - 1;
  rec_t  tbl[5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : act_drv
    forever begin
      @(negedge clk);
      case (mode)
        M_HI:    act_in = 1'b1;
        M_TOG:   act_in = ~act_in;
        default: act_in = 1'b0;
      endcase
    end
  end

  // Scoreboard for level changes plus clk_en period check against the expected level.
  initial begin : mon
    int cnt;
    bit have;
    int ref_lvl;
    cnt = 0;
    have = 0;
    ref_lvl = NL - 1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
        have = 0;
        ref_lvl = NL - 1;
      end else begin
        if (level_chg) begin
          check("chg_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            ref_lvl = exp_q.pop_front();
            check("level_after_chg", int'(level), ref_lvl);
          end
        end
        cnt++;
        if (clk_en) begin
          if (have) check("clk_en_interval", cnt, 1 << (ref_lvl + 1));
          have = 1;
          cnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic resync();
    dfs_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_rec(input int i);
    resync();
    mode = tbl[i].mode;
    while (cur_lvl != tbl[i].exp_lvl) begin
      cur_lvl += (tbl[i].exp_lvl > cur_lvl) ? 1 : -1;
      exp_q.push_back(cur_lvl);
    end
    dfs_en = 1'b1;
    repeat (tbl[i].cycles) @(negedge clk);
    check($sformatf("rec%0d_act_cnt", i), int'(act_cnt), tbl[i].exp_act);
    check($sformatf("rec%0d_level", i), int'(level), tbl[i].exp_lvl);
    check($sformatf("rec%0d_pending_chg", i), exp_q.size(), 0);
  endtask

  initial begin : main
    int n;
    int c;
    bit seen;
    int ivs[$];
    int mn;
    int ord;

    tbl[0] = '{M_HI,  600, 64, 0};
    tbl[1] = '{M_TOG, 600, 32, 0};
    tbl[2] = '{M_LO,  600,  0, 3};
    tbl[3] = '{M_LO,  300,  0, 3};
    tbl[4] = '{M_TOG, 400, 32, 3};

    // Reset state and free-running slowest divider
    repeat (3) @(negedge clk);
    check("rst_level", int'(level), 3);
    check("rst_clk_en", int'(clk_en), 0);
    check("rst_act_cnt", int'(act_cnt), 0);
    check("rst_level_chg", int'(level_chg), 0);
    rst_n = 1'b1;
    n = 1;
    while (!clk_en && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("first_clk_en_after_rst", n, 16);
    repeat (40) @(negedge clk);
    check("idle_level", int'(level), 3);
    check("idle_act_cnt", int'(act_cnt), 0);

    for (int i = 0; i < 2; i++) run_rec(i);

    // Level 0 -> 1 with interval sequence 2 ... 2, 4 ... 4
    resync();
    mode = M_LO;
    exp_q.push_back(1);
    cur_lvl = 1;
    dfs_en = 1'b1;
    c = 0;
    seen = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      c++;
      if (clk_en) begin
        if (seen) ivs.push_back(c);
        seen = 1;
        c = 0;
      end
    end
    check("ivl_count_ok", int'(ivs.size() >= 20), 1);
    if (ivs.size() > 0) begin
      check("ivl_first", ivs[0], 2);
      check("ivl_last", ivs[ivs.size() - 1], 4);
      mn = ivs[0];
      ord = 0;
      for (int k = 1; k < int'(ivs.size()); k++) begin
        if (ivs[k] < mn) mn = ivs[k];
        if (ivs[k] < ivs[k - 1]) ord++;
      end
      check("ivl_min", mn, 2);
      check("ivl_no_return_to_fast", ord, 0);
    end
    check("ivl_level", int'(level), 1);

    for (int i = 2; i < 5; i++) run_rec(i);

    // dfs_en dropped after 20 counted events
    resync();
    mode = M_HI;
    dfs_en = 1'b1;
    repeat (21) @(negedge clk);
    dfs_en = 1'b0;
    repeat (3) @(negedge clk);
    check("drop_act_cnt_held", int'(act_cnt), 32);
    check("drop_level_held", int'(level), 3);
    check("drop_level_chg", int'(level_chg), 0);
    mode = M_LO;
    dfs_en = 1'b1;
    repeat (64) @(negedge clk);
    check("drop_window_not_early", int'(act_cnt), 32);
    @(negedge clk);
    check("drop_counters_cleared", int'(act_cnt), 0);

    // Reset asserted while a 3->2 change is pending
    resync();
    mode = M_HI;
    dfs_en = 1'b1;
    repeat (66) @(negedge clk);
    rst_n = 1'b0;
    dfs_en = 1'b0;
    repeat (2) @(negedge clk);
    check("pend_rst_level", int'(level), 3);
    check("pend_rst_act_cnt", int'(act_cnt), 0);
    check("pend_rst_clk_en", int'(clk_en), 0);
    rst_n = 1'b1;
    n = 1;
    while (!clk_en && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("pend_rst_first_clk_en", n, 16);
    repeat (40) @(negedge clk);
    check("pend_rst_level_after", int'(level), 3);
    check("pend_rst_no_chg", exp_q.size(), 0);

`ifdef DFS_OVERRIDE_EN
    resync();
    mode = M_TOG;
    force_en = 1'b1;
    force_level = 2'd0;
    exp_q.push_back(0);
    cur_lvl = 0;
    dfs_en = 1'b1;
    repeat (90) @(negedge clk);
    check("force_level0", int'(level), 0);
    force_level = 2'd3;
    exp_q.push_back(3);
    cur_lvl = 3;
    repeat (90) @(negedge clk);
    check("force_level3_no_dwell", int'(level), 3);
    force_en = 1'b0;
`endif

    resync();
    check("final_pending_chg", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
